// File: rtl/window_addr_pkg.sv
// Shared types and constants for the serpentine window address generator.
package window_addr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_TURN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Constant distance in words between lane 0 and lane 'lane' of the window.
    function automatic int unsigned lane_offset(input int unsigned lane, input int unsigned pitch);
        return lane * pitch;
    endfunction

endpackage

// File: rtl/window_addr_gen_scan_counter.sv
// Up/down counter with sync clear, load and a direction-aware terminal flag.
module scan_counter #(
    parameter int            W   = 4,
    parameter logic [W-1:0]  MAX = '1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] count,
    output logic         term
);

    // term is the last position in the current counting direction.
    assign term = up ? (count == MAX) : (count == '0);

    // Clear beats load, load beats counting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + W'(1) : count - W'(1);
        end
    end

endmodule

// File: rtl/window_addr_gen.sv
// Serpentine band walker producing WIN column read addresses per cycle.
module window_addr_gen
    import window_addr_pkg::*;
#(
    parameter int IMG_W       = 520,
    parameter int IMG_H       = 520,
    parameter int WIN         = 9,
    parameter int FILL_STAGES = 4,
    parameter int FILL_LEN    = 3,
    parameter int ADDR_W      = 19
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               stall,
    output logic [WIN*ADDR_W-1:0]              addr,
    output logic                               addr_valid,
    output logic                               dir,
    output logic [$clog2(FILL_STAGES+1)-1:0]   fill_level,
    output logic                               row_end,
    output logic                               busy,
    output logic                               frame_done
);

    localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW  = (IMG_H - WIN + 1 > 1) ? $clog2(IMG_H - WIN + 1) : 1;
    localparam int FW  = $clog2(FILL_STAGES + 1);
    localparam int SW  = (FILL_LEN > 1) ? $clog2(FILL_LEN) : 1;
    localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(IMG_W);
    localparam logic [XW-1:0]     X_MAX     = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_H - WIN);
    localparam logic [SW-1:0]     SUB_LAST  = SW'(FILL_LEN - 1);
    localparam logic [FW-1:0]     FILL_SAT  = FW'(FILL_STAGES);

    if (WIN > IMG_H) begin : g_bad_win
        $error("window_addr_gen: WIN must not exceed IMG_H");
    end
    if (FILL_STAGES * FILL_LEN > IMG_W) begin : g_bad_fill
        $error("window_addr_gen: fill span must fit in one row");
    end
    if ((longint'(IMG_W) * longint'(IMG_H)) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("window_addr_gen: ADDR_W too small for the image");
    end

    state_t            state;
    logic [ADDR_W-1:0] row_base;
    logic [YW-1:0]     y;
    logic [XW-1:0]     x;
    logic              x_term;
    logic [SW-1:0]     fill_sub;

    logic go;
    logic accept;
    logic x_en;
    logic y_last;

    assign go     = (state == ST_IDLE) && start;
    assign accept = (state == ST_SCAN) && !stall;
    assign x_en   = accept && !x_term;
    assign y_last = (y == Y_LAST);

    scan_counter #(
        .W   (XW),
        .MAX (X_MAX)
    ) u_x (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (abort || go),
        .load     (1'b0),
        .load_val ('0),
        .en       (x_en),
        .up       (dir == DIR_RIGHT),
        .count    (x),
        .term     (x_term)
    );

    // Band sequencing: state, band row, row base address and scan direction.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            y        <= '0;
            row_base <= '0;
            dir      <= DIR_RIGHT;
        end else if (abort) begin
            state    <= ST_IDLE;
            y        <= '0;
            row_base <= '0;
            dir      <= DIR_RIGHT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SCAN;
                        y        <= '0;
                        row_base <= '0;
                        dir      <= DIR_RIGHT;
                    end
                end
                ST_SCAN: begin
                    if (!stall && x_term) begin
                        state <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    if (!stall) begin
                        if (y_last) begin
                            state <= ST_DONE;
                        end else begin
                            state    <= ST_SCAN;
                            y        <= y + YW'(1);
                            row_base <= row_base + ROW_PITCH;
                            dir      <= ~dir;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Fill progress: one level per FILL_LEN accepted columns, saturating.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fill_sub   <= '0;
            fill_level <= '0;
        end else if (abort || go) begin
            fill_sub   <= '0;
            fill_level <= '0;
        end else if (accept && (fill_level != FILL_SAT)) begin
            if (fill_sub == SUB_LAST) begin
                fill_sub   <= '0;
                fill_level <= fill_level + FW'(1);
            end else begin
                fill_sub <= fill_sub + SW'(1);
            end
        end
    end

    assign addr_valid = (state == ST_SCAN);
    assign row_end    = (state == ST_TURN);
    assign frame_done = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

    for (genvar i = 0; i < WIN; i++) begin : g_lane
        localparam logic [ADDR_W-1:0] LANE_OFF = ADDR_W'(lane_offset(i, IMG_W));
        assign addr[i*ADDR_W +: ADDR_W] = (state == ST_IDLE) ? '0
                                        : row_base + LANE_OFF + ADDR_W'(x);
    end

endmodule

// File: tb/tb_window_addr_gen.sv
// Randomized bench for window_addr_gen checked against a frame-script model.
module tb_window_addr_gen;

    localparam int IMG_W       = 8;
    localparam int IMG_H       = 6;
    localparam int WIN         = 3;
    localparam int FILL_STAGES = 2;
    localparam int FILL_LEN    = 2;
    localparam int ADDR_W      = 6;
    localparam int FW          = $clog2(FILL_STAGES + 1);
    localparam int NB          = IMG_H - WIN + 1;
    localparam int LEN         = NB * (IMG_W + 1) + 1;

    logic                  clk = 1'b0;
    logic                  n_rst;
    logic                  start;
    logic                  abort;
    logic                  stall;
    logic [WIN*ADDR_W-1:0] addr;
    logic                  addr_valid;
    logic                  dir;
    logic [FW-1:0]         fill_level;
    logic                  row_end;
    logic                  busy;
    logic                  frame_done;

    int total = 0;
    int bad   = 0;

    window_addr_gen #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .WIN         (WIN),
        .FILL_STAGES (FILL_STAGES),
        .FILL_LEN    (FILL_LEN),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .abort      (abort),
        .stall      (stall),
        .addr       (addr),
        .addr_valid (addr_valid),
        .dir        (dir),
        .fill_level (fill_level),
        .row_end    (row_end),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Frame script: every step of an unstalled frame, derived from the walk order.
    bit s_valid  [LEN];
    bit s_rowend [LEN];
    bit s_done   [LEN];
    bit s_dir    [LEN];
    int s_lane   [LEN][WIN];

    // Model position inside the script plus idle-time held values.
    bit m_active = 1'b0;
    int m_idx    = 0;
    int m_acc    = 0;
    int m_fill   = 0;
    bit m_dir    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIN*ADDR_W-1:0] lanes3(input int a, input int b, input int c);
        return {ADDR_W'(c), ADDR_W'(b), ADDR_W'(a)};
    endfunction

    function automatic logic [WIN*ADDR_W-1:0] pack_lanes(input int k);
        logic [WIN*ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < WIN; i++) r[i*ADDR_W +: ADDR_W] = ADDR_W'(s_lane[k][i]);
        return r;
    endfunction

    task automatic build_script();
        int k;
        int xc;
        k = 0;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < IMG_W; c++) begin
                xc = (b % 2 == 1) ? IMG_W - 1 - c : c;
                s_valid[k]  = 1'b1;
                s_rowend[k] = 1'b0;
                s_done[k]   = 1'b0;
                s_dir[k]    = (b % 2 == 1);
                for (int i = 0; i < WIN; i++) s_lane[k][i] = (b + i) * IMG_W + xc;
                k++;
            end
            s_valid[k]  = 1'b0;
            s_rowend[k] = 1'b1;
            s_done[k]   = 1'b0;
            s_dir[k]    = (b % 2 == 1);
            for (int i = 0; i < WIN; i++) s_lane[k][i] = s_lane[k-1][i];
            k++;
        end
        s_valid[k]  = 1'b0;
        s_rowend[k] = 1'b0;
        s_done[k]   = 1'b1;
        s_dir[k]    = ((NB - 1) % 2 == 1);
        for (int i = 0; i < WIN; i++) s_lane[k][i] = s_lane[k-1][i];
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_idx    = 0;
        m_acc    = 0;
        m_fill   = 0;
        m_dir    = 1'b0;
    endtask

    task automatic model_step();
        if (abort) begin
            model_reset();
        end else if (!m_active) begin
            if (start) begin
                model_reset();
                m_active = 1'b1;
            end
        end else if (s_done[m_idx]) begin
            m_active = 1'b0;
            m_dir    = s_dir[m_idx];
        end else if (!stall) begin
            if (s_valid[m_idx]) m_acc++;
            m_idx++;
        end
        if (m_active) begin
            m_fill = m_acc / FILL_LEN;
            if (m_fill > FILL_STAGES) m_fill = FILL_STAGES;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) model_reset();
            else model_step();
        end
    end

    // Every falling edge: compare all outputs to what the model position implies.
    initial begin
        forever begin
            @(negedge clk);
            if (m_active) begin
                check("valid", addr_valid, s_valid[m_idx]);
                check("busy", busy, 1);
                check("row_end", row_end, s_rowend[m_idx]);
                check("frame_done", frame_done, s_done[m_idx]);
                check("dir", dir, s_dir[m_idx]);
                check("fill", fill_level, m_fill);
                if (s_valid[m_idx] || s_rowend[m_idx]) check("addr", addr, pack_lanes(m_idx));
            end else begin
                check("idle_valid", addr_valid, 0);
                check("idle_busy", busy, 0);
                check("idle_row_end", row_end, 0);
                check("idle_done", frame_done, 0);
                check("idle_dir", dir, m_dir);
                check("idle_fill", fill_level, m_fill);
                check("idle_addr", addr, 0);
            end
        end
    end

    task automatic applyStimulus(input bit st, input bit ab, input bit sl);
        start = st;
        abort = ab;
        stall = sl;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int busy_cnt;
        int re_cnt;
        int done_cnt;
        bit found;

        n_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        build_script();

        check("script_first", pack_lanes(0), lanes3(0, 8, 16));
        check("script_band1_first", pack_lanes(9), lanes3(15, 23, 31));
        check("script_band1_last", pack_lanes(16), lanes3(8, 16, 24));

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_addr", addr, 0);
        check("reset_fill", fill_level, 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Full unstalled frame with hand-computed landmarks.
        applyStimulus(1'b1, 1'b0, 1'b0);
        start    = 1'b0;
        n        = 0;
        busy_cnt = 0;
        re_cnt   = 0;
        done_cnt = 0;
        while (n < 200) begin
            n++;
            if (!busy) break;
            busy_cnt++;
            re_cnt   += int'(row_end);
            done_cnt += int'(frame_done);
            if (n == 1) begin
                check("first_addr", addr, lanes3(0, 8, 16));
                check("first_dir", dir, 0);
            end
            if (n == 2) check("fill_n2", fill_level, 0);
            if (n == 3) check("fill_n3", fill_level, 1);
            if (n == 5) check("fill_n5", fill_level, 2);
            if (n == 9) begin
                check("turn0_pulse", row_end, 1);
                check("turn0_addr", addr, lanes3(7, 15, 23));
            end
            if (n == 10) begin
                check("band1_addr", addr, lanes3(15, 23, 31));
                check("band1_dir", dir, 1);
            end
            if (n == 18) check("band1_end", addr, lanes3(8, 16, 24));
            if (n == 37) check("done_fill", fill_level, 2);
            @(negedge clk);
        end
        check("busy_cycles", busy_cnt, 37);
        check("row_end_count", re_cnt, 4);
        check("frame_done_count", done_cnt, 1);

        // Stall held for three edges at x=3 of band 0.
        applyStimulus(1'b1, 1'b0, 1'b0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_pre_addr", addr, lanes3(3, 11, 19));
        check("stall_pre_fill", fill_level, 1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_addr", addr, lanes3(3, 11, 19));
            check("stall_valid", addr_valid, 1);
            check("stall_fill", fill_level, 1);
        end
        stall = 1'b0;
        @(negedge clk);
        check("stall_post_addr", addr, lanes3(4, 12, 20));
        check("stall_post_fill", fill_level, 2);

        // Abort together with stall at band 2, x=5.
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (m_active && m_idx == 2 * (IMG_W + 1) + 5) found = 1'b1;
            else @(negedge clk);
        end
        check("abort_reached", found, 1);
        check("abort_pos_addr", addr, lanes3(21, 29, 37));
        applyStimulus(1'b0, 1'b1, 1'b1);
        abort = 1'b0;
        stall = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_addr", addr, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        abort = 1'b0;
        start = 1'b0;
        check("start_abort_idle", busy, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        start = 1'b0;
        check("restart_addr", addr, lanes3(0, 8, 16));

        // Reset asserted in the middle of a TURN cycle.
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (row_end) found = 1'b1;
            else @(negedge clk);
        end
        check("turn_reached", found, 1);
        #1 n_rst = 1'b0;
        #1;
        check("async_rst_addr", addr, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_row_end", row_end, 0);
        check("async_rst_dir", dir, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Start while busy must not restart the walk.
        applyStimulus(1'b1, 1'b0, 1'b0);
        start = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0);
        start = 1'b0;
        check("busy_start_ignored", addr, lanes3(6, 14, 22));

        // Randomized traffic checked continuously by the model.
        for (int k = 0; k < 1500; k++) begin
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 149) == 0,
                          $urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
